// File: rtl/packetizer_da.sv
// packetizer_da: source-side NoC translator.
// Wraps a payload word plus network and return routing fields into a single
// head+tail flit, queues the flits in a small circular FIFO and offers them
// to the fabric with a ready/valid handshake.
// Optional build macro PACKETIZER_DA_STATS_EN adds the pkt_count and
// overflow_attempt status outputs.
module packetizer_da #(
    parameter int WIDTH_PKT        = 36,
    parameter int WIDTH_DATA       = 12,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int DEPTH            = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_DATA-1:0]       data_in,
    input  logic [ADDRESS_WIDTH-1:0]    dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    input  logic [ADDRESS_WIDTH-1:0]    ret_dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] ret_vc_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_PKT-1:0]        data_out,
    output logic                        valid_out,
    input  logic                        ready_in
`ifdef PACKETIZER_DA_STATS_EN
    ,
    output logic [15:0]                 pkt_count,
    output logic                        overflow_attempt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Occupied header+payload bits; anything below them is zero padding.
    localparam int HDR_W = 3 + 2*ADDRESS_WIDTH + 2*VC_ADDRESS_WIDTH + WIDTH_DATA;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (HDR_W > WIDTH_PKT) begin : g_bad_width
        $error("packetizer_da: WIDTH_PKT too small for header fields and payload");
    end
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("packetizer_da: DEPTH must be a power of 2 in 2..16");
    end

    logic [WIDTH_PKT-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [WIDTH_PKT-1:0] pkt_asm;
    logic                 push;
    logic                 pop;

    // Handshake flags come only from registered occupancy, never from valid_in.
    assign ready_out = (count != FULL_CNT);
    assign valid_out = (count != '0);
    assign push      = valid_in && ready_out;
    assign pop       = valid_out && ready_in;

    // Head entry is shown only when something is queued; empty bus reads zero.
    assign data_out  = valid_out ? mem[rd_ptr] : '0;

    // Assemble the flit: valid/head/tail flags, routing fields, payload, zero pad.
    always_comb begin
        pkt_asm = '0;
        pkt_asm[WIDTH_PKT-1 -: HDR_W] = {3'b111, dst_in, vc_in, ret_dst_in, ret_vc_in, data_in};
    end

    // Packet storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt_asm;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PACKETIZER_DA_STATS_EN
    // Popped-packet counter (wraps) and sticky flag for words offered while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count        <= '0;
            overflow_attempt <= 1'b0;
        end else begin
            if (pop) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (valid_in && !ready_out) begin
                overflow_attempt <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_packetizer_da.sv
// Testbench for packetizer_da: scoreboard of expected flits filled when a
// word is offered to a non-full queue and drained as the DUT hands flits off.
module tb_packetizer_da;

    localparam int WIDTH_PKT        = 36;
    localparam int WIDTH_DATA       = 12;
    localparam int VC_ADDRESS_WIDTH = 1;
    localparam int ADDRESS_WIDTH    = 4;
    localparam int DEPTH            = 4;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [WIDTH_DATA-1:0]       data_in = '0;
    logic [ADDRESS_WIDTH-1:0]    dst_in = '0;
    logic [VC_ADDRESS_WIDTH-1:0] vc_in = '0;
    logic [ADDRESS_WIDTH-1:0]    ret_dst_in = '0;
    logic [VC_ADDRESS_WIDTH-1:0] ret_vc_in = '0;
    logic                        valid_in = 1'b0;
    logic                        ready_out;
    logic [WIDTH_PKT-1:0]        data_out;
    logic                        valid_out;
    logic                        ready_in = 1'b0;
`ifdef PACKETIZER_DA_STATS_EN
    logic [15:0]                 pkt_count;
    logic                        overflow_attempt;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int pops  = 0;
    logic [WIDTH_PKT-1:0] exp_q [$];

    packetizer_da #(
        .WIDTH_PKT(WIDTH_PKT),
        .WIDTH_DATA(WIDTH_DATA),
        .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .dst_in(dst_in),
        .vc_in(vc_in),
        .ret_dst_in(ret_dst_in),
        .ret_vc_in(ret_vc_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_in(ready_in)
`ifdef PACKETIZER_DA_STATS_EN
        ,
        .pkt_count(pkt_count),
        .overflow_attempt(overflow_attempt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH_PKT-1:0] mk_pkt(
        input logic [11:0] d, input logic [3:0] ds, input logic v,
        input logic [3:0] rd, input logic rv);
        return {3'b111, ds, v, rd, rv, d, 11'b0};
    endfunction

    // Scoreboard: sample mid-cycle, check flags and head flit, then account
    // for the handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pops = 0;
        end else begin
            automatic bit was_full = (exp_q.size() == DEPTH);
            chk("valid_out", {63'b0, valid_out}, {63'b0, exp_q.size() != 0});
            chk("ready_out", {63'b0, ready_out}, {63'b0, !was_full});
            if (exp_q.size() != 0) begin
                chk("data_out", 64'(data_out), 64'(exp_q[0]));
                if (ready_in) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end else begin
                chk("data_idle", 64'(data_out), 64'd0);
            end
            if (valid_in && !was_full) begin
                exp_q.push_back(mk_pkt(data_in, dst_in, vc_in, ret_dst_in, ret_vc_in));
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_word();
        data_in    = WIDTH_DATA'($urandom);
        dst_in     = ADDRESS_WIDTH'($urandom);
        vc_in      = VC_ADDRESS_WIDTH'($urandom);
        ret_dst_in = ADDRESS_WIDTH'($urandom);
        ret_vc_in  = VC_ADDRESS_WIDTH'($urandom);
    endtask

    initial begin
        int p0;
        // Reset state
        #2;
        chk("rst_valid", {63'b0, valid_out}, 64'd0);
        chk("rst_ready", {63'b0, ready_out}, 64'd1);
        chk("rst_data", 64'(data_out), 64'd0);
`ifdef PACKETIZER_DA_STATS_EN
        chk("rst_cnt", 64'(pkt_count), 64'd0);
        chk("rst_ovf", {63'b0, overflow_attempt}, 64'd0);
`endif
        step(2);
        rst_n = 1'b1;
        step(1);

        // Single known packet, one-cycle latency
        data_in = 12'hABC; dst_in = 4'h5; vc_in = 1'b1; ret_dst_in = 4'h9; ret_vc_in = 1'b0;
        valid_in = 1'b1;
        step(1);
        valid_in = 1'b0;
        chk("lat_valid", {63'b0, valid_out}, 64'd1);
        chk("lat_pkt", 64'(data_out), 64'h0_EB955E000);
        ready_in = 1'b1;
        step(2);
        ready_in = 1'b0;
        chk("lat_drained", {63'b0, valid_out}, 64'd0);

        // Fill past capacity with the sink stalled, then drain in order
        for (int i = 0; i < 5; i++) begin
            rand_word();
            valid_in = 1'b1;
            step(1);
        end
        valid_in = 1'b0;
        chk("full_ready", {63'b0, ready_out}, 64'd0);
        p0 = pops;
        ready_in = 1'b1;
        step(6);
        chk("full_npop", 64'(pops - p0), 64'd4);
        chk("full_empty", {63'b0, valid_out}, 64'd0);

        // Streaming with sink always ready: 20 words, wrap pointers
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            rand_word();
            valid_in = 1'b1;
            step(1);
        end
        valid_in = 1'b0;
        step(3);
        chk("stream_npop", 64'(pops - p0), 64'd20);
        ready_in = 1'b0;

        // Full queue, then offer and pop together: pop only
        for (int i = 0; i < 4; i++) begin
            rand_word();
            valid_in = 1'b1;
            step(1);
        end
        chk("sim_full", {63'b0, ready_out}, 64'd0);
        rand_word();
        ready_in = 1'b1;
        step(1);
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("sim_ready", {63'b0, ready_out}, 64'd1);
        chk("sim_valid", {63'b0, valid_out}, 64'd1);
        ready_in = 1'b1;
        step(4);
        ready_in = 1'b0;

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) begin
            rand_word();
            valid_in = 1'b1;
            step(1);
        end
        valid_in = 1'b0;
        chk("pre_rst_valid", {63'b0, valid_out}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'b0, valid_out}, 64'd0);
        chk("arst_data", 64'(data_out), 64'd0);
        chk("arst_ready", {63'b0, ready_out}, 64'd1);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Statistics: 3 pops, then an offer while full
        for (int i = 0; i < 3; i++) begin
            rand_word();
            valid_in = 1'b1;
            step(1);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        step(3);
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_word();
            valid_in = 1'b1;
            step(1);
        end
        valid_in = 1'b0;
        chk("st_full", {63'b0, ready_out}, 64'd0);
`ifdef PACKETIZER_DA_STATS_EN
        chk("st_cnt", 64'(pkt_count), 64'd3);
        chk("st_cnt_model", 64'(pkt_count), 64'(pops));
        chk("st_ovf", {63'b0, overflow_attempt}, 64'd1);
        step(3);
        chk("st_cnt_hold", 64'(pkt_count), 64'd3);
        chk("st_ovf_hold", {63'b0, overflow_attempt}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("st_rst_cnt", 64'(pkt_count), 64'd0);
        chk("st_rst_ovf", {63'b0, overflow_attempt}, 64'd0);
        step(1);
        rst_n = 1'b1;
`endif
        ready_in = 1'b1;
        step(6);
        chk("end_empty", {63'b0, valid_out}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
